// File: rtl/scroll_pkg.sv
// Shared encodings for the scrolling-roller scan controller.
// Display pins are active low: a 0 bit lights a segment or enables a digit.
package scroll_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    STEP  = 2'd2
  } state_t;

  // Segment order is {g,f,e,d,c,b,a}; 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit enables are active low; all ones turns every digit off.
  localparam logic [3:0] AN_NONE = 4'hF;

  function automatic logic [3:0] an_select_n(input logic [1:0] idx);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << idx;
    return ~one_hot;
  endfunction

endpackage

// File: rtl/scroll_scan_ctrl_if.sv
// Button, roller-digit and display-pin bundle of the scan controller.
// master is the controller side, slave is the board/roller side.
interface scroll_scan_ctrl_if;
  logic       btn_pause;
  logic       btn_step;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] d4;
  logic       off;
  logic [3:0] an;
  logic [6:0] seg;
  logic       run;

  modport master (
    input  btn_pause, btn_step, d1, d2, d3, d4,
    output off, an, seg, run
  );

  modport slave (
    output btn_pause, btn_step, d1, d2, d3, d4,
    input  off, an, seg, run
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// BCD to active-low seven-segment decoder; codes 10..15 show a blank digit.
module bcd_to_seg7
  import scroll_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scroll_scan_ctrl.sv
// Run/pause/single-step sequencer for the scrolling roller plus the
// four-digit multiplexed display scan that shares its free-running counters.
module scroll_scan_ctrl
  import scroll_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int STEP_DIV = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  scroll_scan_ctrl_if.master    bus
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(STEP_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               step_tick;

  logic pause_cur, pause_prev, step_cur, step_prev;
  logic pause_edge, step_edge;

  state_t state, next_state;
  logic   fire;

  logic [3:0] cur_digit;
  logic [6:0] seg_dec;

  logic       off_q;
  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       run_q;

  // Counters never stop or reload except on reset, so the step cadence
  // stays locked to the scan regardless of pause and single-step activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      idx       <= 2'd0;
      frame_cnt <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
      if (idx == 2'd3) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign step_tick = (scan_cnt == SCAN_LAST) && (idx == 2'd3) && (frame_cnt == FRAME_LAST);

  // History resets high so a button already held at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pause_cur  <= 1'b1;
      pause_prev <= 1'b1;
      step_cur   <= 1'b1;
      step_prev  <= 1'b1;
    end else begin
      pause_cur  <= bus.btn_pause;
      pause_prev <= pause_cur;
      step_cur   <= bus.btn_step;
      step_prev  <= step_cur;
    end
  end

  assign pause_edge = pause_cur & ~pause_prev;
  assign step_edge  = step_cur & ~step_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      off_q <= 1'b1;
      run_q <= 1'b1;
      an_q  <= AN_NONE;
      seg_q <= SEG_BLANK;
    end else begin
      state <= next_state;
      off_q <= ~fire;
      run_q <= (next_state == RUN);
      an_q  <= an_select_n(idx);
      seg_q <= seg_dec;
    end
  end

  // A pause edge outranks a coincident step tick, so that step is lost.
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    case (state)
      RUN: begin
        if (pause_edge) begin
          next_state = PAUSE;
        end else if (step_tick) begin
          fire = 1'b1;
        end
      end
      PAUSE: begin
        if (pause_edge) begin
          next_state = RUN;
        end else if (step_edge) begin
          next_state = STEP;
          fire       = 1'b1;
        end
      end
      STEP:    next_state = PAUSE;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    cur_digit = bus.d1;
    case (idx)
      2'd0:    cur_digit = bus.d1;
      2'd1:    cur_digit = bus.d2;
      2'd2:    cur_digit = bus.d3;
      default: cur_digit = bus.d4;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (seg_dec)
  );

  assign bus.off = off_q;
  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.run = run_q;

endmodule

// File: doc/scroll_scan_ctrl.md
# scroll_scan_ctrl

Controller that sequences the four-digit scrolling roller and drives a shared, time-multiplexed four-digit seven-segment display. It generates the roller's step enable and implements run/pause/single-step control from two debounced buttons. It scans digits d1..d4 onto one segment bus with active-low digit enables. It sits between the roller datapath and the board display pins.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot, ≥2
- STEP_DIV, 100: full scan frames (4 slots) per scroll step in RUN, ≥1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- btn_pause  in  1  debounced level; each rising edge toggles RUN/PAUSE
- btn_step  in  1  debounced level; rising edge in PAUSE issues one step
- d1..d4  in  4 each  BCD digits from the roller (d1 rightmost)
- off  out  1  roller hold; low for exactly one clk per step, else high
- an  out  4  digit enables, active low, an[0] = d1
- seg  out  7  {g,f,e,d,c,b,a}, active low
- run  out  1  high in RUN

## Operation
- States: RUN, PAUSE, STEP. Reset → RUN.
- Edge detect: register both buttons; an edge is current=1 and previous=0. Previous-value registers reset to 1, so a button held through reset gives no edge.
- RUN: a pause edge goes to PAUSE. Step tick → off low for one cycle.
- PAUSE: a pause edge goes to RUN. A step edge goes to STEP. Step ticks are ignored.
- STEP: off low this cycle; next state PAUSE unconditionally. Edges in this cycle are dropped.
- Step edges in RUN are ignored.
- A pause edge in the same cycle as a RUN step tick goes to PAUSE; no step is issued.
- Scan counter: 0..SCAN_DIV-1, wraps. At wrap, idx (0..3) advances 0→1→2→3→0. When idx wraps 3→0, the frame counter (0..STEP_DIV-1) advances. Step tick = frame, idx and scan counters all at terminal. The scan runs in every state.
- Display: an = ~(1<<idx). seg = decode(d[idx]). Values 10..15 give blank (7'h7F).
- Decode: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).

## Timing
- Reset values (cycle after rst_n sampled low): off=1, an=4'hF, seg=7'h7F, run=1, state RUN, all counters 0.
- an, seg, off and run are registered. an/seg reflect idx/d from the previous cycle, giving 1-cycle latency from a change on d[idx] to seg.
- With idx=0, the first an=4'hE appears the cycle after rst_n is first sampled high.
- RUN step period = 4·SCAN_DIV·STEP_DIV cycles exactly. The first off-low cycle is at edge number 4·SCAN_DIV·STEP_DIV after release.
- Button edge to state change: 2 cycles (sync register plus state register). run follows the state with no extra delay beyond its register.
- Counters are not disturbed by pause or step; the step cadence realigns only on reset.
- Reset mid-step forces off=1 on that edge.

## Structure
- Package scroll_pkg holds:
  - state encoding (RUN=2'd0, PAUSE=2'd1, STEP=2'd2);
  - seven-segment constants SEG_0..SEG_9 and SEG_BLANK;
  - active-low polarity notes.
- Sub-module bcd_to_seg7 (combinational, 4-bit in, 7-bit out) is shared with other display users. Counters and the FSM stay in the top.

## Test plan
- Reset: SCAN_DIV=4, STEP_DIV=2, hold rst_n low 3 cycles → off=1, an=F, seg=7F, run=1. After release: off low for one cycle at edge 32, 64 and 96, high elsewhere.
- Scan: d1..d4 = 9,6,2,9 → an sequence E,D,B,7, 4 cycles each. seg = 10,02,24,10 aligned with the matching an.
- Pause/step: pulse btn_pause → run=0 two cycles later; no off pulses for 200 cycles. Three btn_step pulses → exactly three single-cycle off lows. btn_step while running → no extra off.
- Collision: assert the btn_pause edge so it lands on the step-tick cycle → state PAUSE, off stays 1.
- Blank/reset mid-op: d3=4'hC → seg=7F during an=B. Assert rst_n low during the STEP cycle → off=1 at that edge, state RUN after release.
